// File: rtl/kyber_pkg.sv
// kyber_pkg: Kyber polynomial constants and the serializer state encoding
package kyber_pkg;
    localparam int KYBER_N = 256;
    localparam int KYBER_Q = 3329;
    localparam int POLY_BYTES = 3 * KYBER_N / 2;
    typedef enum logic [2:0] {IDLE, GET0, GET1, EMIT, DONE} state_t;
endpackage

// File: rtl/coeff_csubq.sv
// coeff_csubq: conditional subtract of Q, mapping [0, 2Q) to the canonical 12-bit range
module coeff_csubq
    import kyber_pkg::*;
#(
    parameter int i_Width = 16
) (
    input  logic [i_Width-1:0] coeff,
    output logic [11:0]        canon
);
    localparam logic [i_Width-1:0] QW = i_Width'(KYBER_Q);
    // Q fits in 12 bits, so subtracting in 12 bits equals (c-Q)[11:0]
    always_comb canon = (coeff >= QW) ? coeff[11:0] - 12'(KYBER_Q) : coeff[11:0];
endmodule

// File: rtl/poly_tobytes_serializer.sv
// poly_tobytes_serializer: packs 256 coefficients into 384 bytes, three bytes per
// coefficient pair, over valid/ready handshakes on both sides.
module poly_tobytes_serializer
    import kyber_pkg::*;
#(
    parameter int i_Width = 16,
    parameter int o_Width = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               iCoeff_valid,
    input  logic [i_Width-1:0] iCoeff,
    output logic               iCoeff_ready,
    output logic               oByte_valid,
    output logic [o_Width-1:0] oByte,
    input  logic               oByte_ready,
    output logic               oLast,
    output logic               busy,
    output logic               done
);
    localparam int PW = $clog2(KYBER_N / 2);
    localparam logic [PW-1:0] LAST_PAIR = PW'(KYBER_N / 2 - 1);
    state_t        state;
    logic [PW-1:0] pair_cnt;
    logic [1:0]    byte_idx;
    logic [11:0]   t0, t1, t;
    coeff_csubq #(.i_Width(i_Width)) u_csubq (.coeff(iCoeff), .canon(t));
    // Outputs are registered alongside the state, so each is loaded for the state being entered
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            pair_cnt     <= '0;
            byte_idx     <= '0;
            t0           <= '0;
            t1           <= '0;
            iCoeff_ready <= 1'b0;
            oByte_valid  <= 1'b0;
            oByte        <= '0;
            oLast        <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state        <= GET0;
                    pair_cnt     <= '0;
                    iCoeff_ready <= 1'b1;
                    busy         <= 1'b1;
                end
                GET0: if (iCoeff_valid) begin
                    t0    <= t;
                    state <= GET1;
                end
                GET1: if (iCoeff_valid) begin
                    t1           <= t;
                    state        <= EMIT;
                    byte_idx     <= 2'd0;
                    iCoeff_ready <= 1'b0;
                    oByte_valid  <= 1'b1;
                    oByte        <= o_Width'(t0[7:0]);
                    oLast        <= 1'b0;
                end
                EMIT: if (oByte_ready) begin
                    if (byte_idx == 2'd2) begin
                        oByte_valid <= 1'b0;
                        oLast       <= 1'b0;
                        if (pair_cnt == LAST_PAIR) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            pair_cnt     <= pair_cnt + 1'b1;
                            state        <= GET0;
                            iCoeff_ready <= 1'b1;
                        end
                    end else begin
                        byte_idx <= byte_idx + 1'b1;
                        oByte    <= (byte_idx == 2'd0) ? o_Width'({t1[3:0], t0[11:8]}) : o_Width'(t1[11:4]);
                        oLast    <= (byte_idx == 2'd1) && (pair_cnt == LAST_PAIR);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_poly_tobytes_serializer.sv
// tb_poly_tobytes_serializer: scoreboard bench; the feeder pushes expected bytes per pair,
// a negedge monitor pops and compares every accepted byte.
module tb_poly_tobytes_serializer;
    import kyber_pkg::*;
    logic        clk = 1'b0;
    logic        rst, start, iCoeff_valid, iCoeff_ready, oByte_valid, oByte_ready, oLast, busy, done;
    logic [15:0] iCoeff;
    logic [7:0]  oByte;
    int          n_checks = 0, n_fail = 0;
    int          cyc = 0, rx_total = 0, done_cnt = 0, stall_at = -1, stall_left = 0;
    bit          abort = 0, use_hand = 0, held = 0;
    logic [7:0]  held_byte;
    logic        held_last;
    logic [8:0]  sb [$];
    int          coeffs [KYBER_N];
    logic [7:0]  hand [6] = '{8'h23, 8'h61, 8'h45, 8'h00, 8'h00, 8'hD0};

    poly_tobytes_serializer #(.i_Width(16), .o_Width(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .iCoeff_valid(iCoeff_valid), .iCoeff(iCoeff), .iCoeff_ready(iCoeff_ready),
        .oByte_valid(oByte_valid), .oByte(oByte), .oByte_ready(oByte_ready),
        .oLast(oLast), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [11:0] canon(input int c);
        return 12'((c >= KYBER_Q) ? c - KYBER_Q : c);
    endfunction

    function automatic void push_pair(input int k, input int c0, input int c1);
        logic [23:0] v;
        v = 24'(canon(c0)) + (24'(canon(c1)) << 12);
        for (int b = 0; b < 3; b++)
            if (use_hand && k < 2) sb.push_back({1'b0, hand[k*3+b]});
            else sb.push_back({(k == KYBER_N/2-1) && (b == 2), v[8*b +: 8]});
    endfunction

    task automatic feed(input bit gaps);
        int to;
        for (int i = 0; i < KYBER_N && !abort; i++) begin
            if (i % 2 == 1) push_pair(i / 2, coeffs[i-1], coeffs[i]);
            if (gaps) while (!abort && $urandom_range(0, 2) == 0) begin
                iCoeff_valid = 1'b0;
                @(negedge clk);
            end
            iCoeff = 16'(coeffs[i]);
            iCoeff_valid = 1'b1;
            to = 0;
            while (!iCoeff_ready && !abort && to < 2000) begin
                @(negedge clk);
                to++;
            end
            if (to >= 2000) check("feed_timeout", 1, 0);
            if (!abort) @(negedge clk);
        end
        iCoeff_valid = 1'b0;
    endtask

    task automatic run_poly(input bit gaps, input bit timed, input int stall_off, input bit pulse_busy);
        int s, d0, r0, to;
        d0 = done_cnt;
        r0 = rx_total;
        @(negedge clk);
        start = 1'b1;
        s = cyc;
        if (stall_off >= 0) stall_at = rx_total + stall_off;
        fork
            feed(gaps);
            begin
                @(negedge clk);
                start = 1'b0;
                if (pulse_busy) begin
                    repeat (30) @(negedge clk);
                    start = 1'b1;
                    @(negedge clk);
                    start = 1'b0;
                end
            end
        join
        to = 0;
        while (!done && to < 5000) begin
            @(negedge clk);
            to++;
        end
        check("done_pulse", done, 1);
        if (timed) check("done_cycle", cyc - s, 641);
        @(negedge clk);
        if (timed) check("idle_cycle", cyc - s, 642);
        check("busy_after_done", busy, 0);
        check("done_width", done, 0);
        check("done_count", done_cnt - d0, 1);
        check("byte_count", rx_total - r0, POLY_BYTES);
        check("scoreboard_empty", sb.size(), 0);
    endtask

    // monitor: drives consumer ready (with optional stall) and scores accepted bytes
    initial begin
        logic [8:0] e;
        oByte_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (oByte_valid && !rst && rx_total == stall_at) begin
                stall_left = 4;
                stall_at = -1;
            end
            oByte_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            if (done) done_cnt++;
            if (oByte_valid && !rst) begin
                check("in_ready_during_emit", iCoeff_ready, 0);
                if (held) begin
                    check("held_byte", oByte, held_byte);
                    check("held_last", oLast, held_last);
                end
                if (oByte_ready) begin
                    if (sb.size() == 0) check("unexpected_byte", 1, 0);
                    else begin
                        e = sb.pop_front();
                        check("byte", oByte, e[7:0]);
                        check("last", oLast, e[8]);
                    end
                    rx_total++;
                end
                held = !oByte_ready;
                held_byte = oByte;
                held_last = oLast;
            end else held = 0;
        end
    end

    initial begin
        int to, r0;
        rst = 1'b1; start = 1'b0; iCoeff_valid = 1'b0; iCoeff = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", iCoeff_ready, 0);
        check("rst_out_valid", oByte_valid, 0);
        check("rst_byte", oByte, 0);
        check("rst_last", oLast, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        // hand-computed pairs, including canonicalisation of Q and 2Q-1
        for (int i = 0; i < KYBER_N; i++) coeffs[i] = i % KYBER_Q;
        coeffs[0] = 'h123; coeffs[1] = 'h456; coeffs[2] = 3329; coeffs[3] = 6657;
        use_hand = 1;
        run_poly(0, 0, -1, 0);
        use_hand = 0;
        for (int i = 0; i < KYBER_N; i++) coeffs[i] = i % KYBER_Q;
        run_poly(0, 1, -1, 0);
        run_poly(1, 0, 150, 1);
        // reset after 100 bytes
        r0 = rx_total;
        @(negedge clk);
        start = 1'b1;
        fork
            feed(0);
            begin
                @(negedge clk);
                start = 1'b0;
                to = 0;
                while (rx_total < r0 + 100 && to < 2000) begin
                    @(negedge clk);
                    to++;
                end
                check("bytes_before_rst", rx_total - r0 >= 100, 1);
                @(posedge clk);
                #1;
                rst = 1'b1;
                abort = 1;
                sb.delete();
            end
        join
        @(posedge clk);
        #1;
        check("midrst_state", int'(dut.state), int'(IDLE));
        check("midrst_in_ready", iCoeff_ready, 0);
        check("midrst_out_valid", oByte_valid, 0);
        check("midrst_byte", oByte, 0);
        check("midrst_last", oLast, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        rst = 1'b0;
        abort = 0;
        iCoeff_valid = 1'b0;
        run_poly(0, 1, -1, 0);
        // start coinciding with rst
        @(negedge clk);
        start = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_start_state", int'(dut.state), int'(IDLE));
        check("rst_start_busy", busy, 0);
        check("rst_start_ready", iCoeff_ready, 0);
        start = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_start_stays_idle", busy, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
